axi2wbm: RTL



---
 rtl/axi2wbm_pkg.sv | 27 ++
 rtl/axi2wbm_if.sv | 84 ++++++++
 rtl/axi2wbm.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/axi2wbm_pkg.sv
// Shared types and constants for the AXI4-slave to Wishbone-master bridge.
package axi2wbm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WR_STB,
    WR_ACK,
    WR_RESP,
    RD_STB,
    RD_ACK,
    RD_RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // WRAP is handled like INCR; only FIXED holds the word address still.
  function automatic logic addr_step(input logic [1:0] burst);
    return (burst != BURST_FIXED);
  endfunction

endpackage

// File: rtl/axi2wbm_if.sv
// AXI4 slave channels plus pipelined Wishbone master signals of the bridge.
// The slave modport is the bridge's view; master is the initiator/peripheral side.
interface axi2wbm_if #(
  parameter int C_AXI_ADDR_WIDTH = 34,
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ID_WIDTH   = 1
);
  localparam int AW = C_AXI_ADDR_WIDTH - 2;
  localparam int SW = C_AXI_DATA_WIDTH / 8;

  logic                        axi_awvalid;
  logic                        axi_awready;
  logic [C_AXI_ID_WIDTH-1:0]   axi_awid;
  logic [C_AXI_ADDR_WIDTH-1:0] axi_awaddr;
  logic [7:0]                  axi_awlen;
  logic [1:0]                  axi_awburst;

  logic                        axi_wvalid;
  logic                        axi_wready;
  logic [C_AXI_DATA_WIDTH-1:0] axi_wdata;
  logic [SW-1:0]               axi_wstrb;
  logic                        axi_wlast;

  logic                        axi_bvalid;
  logic                        axi_bready;
  logic [C_AXI_ID_WIDTH-1:0]   axi_bid;
  logic [1:0]                  axi_bresp;

  logic                        axi_arvalid;
  logic                        axi_arready;
  logic [C_AXI_ID_WIDTH-1:0]   axi_arid;
  logic [C_AXI_ADDR_WIDTH-1:0] axi_araddr;
  logic [7:0]                  axi_arlen;
  logic [1:0]                  axi_arburst;

  logic                        axi_rvalid;
  logic                        axi_rready;
  logic [C_AXI_ID_WIDTH-1:0]   axi_rid;
  logic [C_AXI_DATA_WIDTH-1:0] axi_rdata;
  logic [1:0]                  axi_rresp;
  logic                        axi_rlast;

  logic                        wb_cyc;
  logic                        wb_stb;
  logic                        wb_we;
  logic [AW-1:0]               wb_addr;
  logic [C_AXI_DATA_WIDTH-1:0] wb_wdata;
  logic [SW-1:0]               wb_sel;
  logic                        wb_stall;
  logic                        wb_ack;
  logic                        wb_err;
  logic [C_AXI_DATA_WIDTH-1:0] wb_rdata;

  modport slave (
    input  axi_awvalid, axi_awid, axi_awaddr, axi_awlen, axi_awburst,
    output axi_awready,
    input  axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
    output axi_wready,
    output axi_bvalid, axi_bid, axi_bresp,
    input  axi_bready,
    input  axi_arvalid, axi_arid, axi_araddr, axi_arlen, axi_arburst,
    output axi_arready,
    output axi_rvalid, axi_rid, axi_rdata, axi_rresp, axi_rlast,
    input  axi_rready,
    output wb_cyc, wb_stb, wb_we, wb_addr, wb_wdata, wb_sel,
    input  wb_stall, wb_ack, wb_err, wb_rdata
  );

  modport master (
    output axi_awvalid, axi_awid, axi_awaddr, axi_awlen, axi_awburst,
    input  axi_awready,
    output axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
    input  axi_wready,
    input  axi_bvalid, axi_bid, axi_bresp,
    output axi_bready,
    output axi_arvalid, axi_arid, axi_araddr, axi_arlen, axi_arburst,
    input  axi_arready,
    input  axi_rvalid, axi_rid, axi_rdata, axi_rresp, axi_rlast,
    output axi_rready,
    input  wb_cyc, wb_stb, wb_we, wb_addr, wb_wdata, wb_sel,
    output wb_stall, wb_ack, wb_err, wb_rdata
  );

endinterface

// File: rtl/axi2wbm.sv
// AXI4 slave to pipelined Wishbone master bridge: one transaction at a time,
// fair write/read arbitration, bursts expanded into single-beat Wishbone cycles.
module axi2wbm
  import axi2wbm_pkg::*;
#(
  parameter int C_AXI_ADDR_WIDTH = 34,
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ID_WIDTH   = 1
) (
  input logic      i_clk,
  input logic      i_reset_n,
  axi2wbm_if.slave bus
);
  localparam int AW = C_AXI_ADDR_WIDTH - 2;
  localparam int SW = C_AXI_DATA_WIDTH / 8;

  state_t                      state_reg;
  logic                        last_grant_wr_reg;
  logic                        err_acc_reg;
  logic [7:0]                  beats_reg;
  logic [C_AXI_ID_WIDTH-1:0]   id_reg;
  logic [1:0]                  burst_reg;
  logic [AW-1:0]               wb_addr_reg;
  logic [C_AXI_DATA_WIDTH-1:0] wb_data_reg;
  logic [SW-1:0]               wb_sel_reg;
  logic                        wb_cyc_reg;
  logic                        wb_stb_reg;
  logic                        wb_we_reg;
  logic                        wready_reg;
  logic                        bvalid_reg;
  logic [1:0]                  bresp_reg;
  logic                        rvalid_reg;
  logic [C_AXI_DATA_WIDTH-1:0] rdata_reg;
  logic [1:0]                  rresp_reg;
  logic                        rlast_reg;

  logic          grant_wr;
  logic          grant_rd;
  logic          aw_hs;
  logic          ar_hs;
  logic          wb_done;
  logic [AW-1:0] addr_next;
  logic          unused_bits;

  // On a tie the channel not served last wins.
  assign grant_wr  = bus.axi_awvalid && (!bus.axi_arvalid || !last_grant_wr_reg);
  assign grant_rd  = bus.axi_arvalid && (!bus.axi_awvalid || last_grant_wr_reg);
  assign aw_hs     = (state_reg == IDLE) && grant_wr;
  assign ar_hs     = (state_reg == IDLE) && grant_rd;
  assign wb_done   = bus.wb_ack || bus.wb_err;
  assign addr_next = wb_addr_reg + AW'(addr_step(burst_reg));

  // wlast is not needed: the captured beat count drives sequencing.
  assign unused_bits = ^{bus.axi_wlast, bus.axi_awaddr[1:0], bus.axi_araddr[1:0]};

  assign bus.axi_awready = aw_hs;
  assign bus.axi_arready = ar_hs;
  assign bus.axi_wready  = wready_reg;
  assign bus.axi_bvalid  = bvalid_reg;
  assign bus.axi_bid     = id_reg;
  assign bus.axi_bresp   = bresp_reg;
  assign bus.axi_rvalid  = rvalid_reg;
  assign bus.axi_rid     = id_reg;
  assign bus.axi_rdata   = rdata_reg;
  assign bus.axi_rresp   = rresp_reg;
  assign bus.axi_rlast   = rlast_reg;
  assign bus.wb_cyc      = wb_cyc_reg;
  assign bus.wb_stb      = wb_stb_reg;
  assign bus.wb_we       = wb_we_reg;
  assign bus.wb_addr     = wb_addr_reg;
  assign bus.wb_wdata    = wb_data_reg;
  assign bus.wb_sel      = wb_sel_reg;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_reg         <= IDLE;
      last_grant_wr_reg <= 1'b0;
      err_acc_reg       <= 1'b0;
      beats_reg         <= '0;
      id_reg            <= '0;
      burst_reg         <= '0;
      wb_addr_reg       <= '0;
      wb_data_reg       <= '0;
      wb_sel_reg        <= '0;
      wb_cyc_reg        <= 1'b0;
      wb_stb_reg        <= 1'b0;
      wb_we_reg         <= 1'b0;
      wready_reg        <= 1'b0;
      bvalid_reg        <= 1'b0;
      bresp_reg         <= RESP_OKAY;
      rvalid_reg        <= 1'b0;
      rdata_reg         <= '0;
      rresp_reg         <= RESP_OKAY;
      rlast_reg         <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (aw_hs) begin
            last_grant_wr_reg <= 1'b1;
            id_reg            <= bus.axi_awid;
            wb_addr_reg       <= bus.axi_awaddr[C_AXI_ADDR_WIDTH-1:2];
            beats_reg         <= bus.axi_awlen;
            burst_reg         <= bus.axi_awburst;
            wready_reg        <= 1'b1;
            state_reg         <= WR_DATA;
          end else if (ar_hs) begin
            last_grant_wr_reg <= 1'b0;
            id_reg            <= bus.axi_arid;
            wb_addr_reg       <= bus.axi_araddr[C_AXI_ADDR_WIDTH-1:2];
            beats_reg         <= bus.axi_arlen;
            burst_reg         <= bus.axi_arburst;
            wb_cyc_reg        <= 1'b1;
            wb_stb_reg        <= 1'b1;
            wb_we_reg         <= 1'b0;
            wb_sel_reg        <= '1;
            state_reg         <= RD_STB;
          end
        end
        WR_DATA: begin
          if (bus.axi_wvalid) begin
            wb_data_reg <= bus.axi_wdata;
            wb_sel_reg  <= bus.axi_wstrb;
            wready_reg  <= 1'b0;
            wb_cyc_reg  <= 1'b1;
            wb_stb_reg  <= 1'b1;
            wb_we_reg   <= 1'b1;
            state_reg   <= WR_STB;
          end
        end
        WR_STB: begin
          if (!bus.wb_stall) begin
            wb_stb_reg <= 1'b0;
            state_reg  <= WR_ACK;
          end
        end
        WR_ACK: begin
          if (wb_done) begin
            // cyc is released between beats so a slow W channel never holds the bus.
            wb_cyc_reg <= 1'b0;
            wb_we_reg  <= 1'b0;
            if (beats_reg != 8'd0) begin
              err_acc_reg <= err_acc_reg | bus.wb_err;
              wb_addr_reg <= addr_next;
              beats_reg   <= beats_reg - 8'd1;
              wready_reg  <= 1'b1;
              state_reg   <= WR_DATA;
            end else begin
              err_acc_reg <= err_acc_reg | bus.wb_err;
              bvalid_reg  <= 1'b1;
              bresp_reg   <= (err_acc_reg | bus.wb_err) ? RESP_SLVERR : RESP_OKAY;
              state_reg   <= WR_RESP;
            end
          end
        end
        WR_RESP: begin
          if (bus.axi_bready) begin
            bvalid_reg  <= 1'b0;
            err_acc_reg <= 1'b0;
            state_reg   <= IDLE;
          end
        end
        RD_STB: begin
          if (!bus.wb_stall) begin
            wb_stb_reg <= 1'b0;
            state_reg  <= RD_ACK;
          end
        end
        RD_ACK: begin
          if (wb_done) begin
            wb_cyc_reg <= 1'b0;
            rvalid_reg <= 1'b1;
            rdata_reg  <= bus.wb_rdata;
            rresp_reg  <= bus.wb_err ? RESP_SLVERR : RESP_OKAY;
            rlast_reg  <= (beats_reg == 8'd0);
            state_reg  <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (bus.axi_rready) begin
            rvalid_reg <= 1'b0;
            rlast_reg  <= 1'b0;
            if (rlast_reg) begin
              state_reg <= IDLE;
            end else begin
              wb_addr_reg <= addr_next;
              beats_reg   <= beats_reg - 8'd1;
              wb_cyc_reg  <= 1'b1;
              wb_stb_reg  <= 1'b1;
              state_reg   <= RD_STB;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
